// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multicycle processor control unit:
// FSM states, opcodes, datapath select encodings and the control-word layout.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_RTEXEC,
    S_RTWB,
    S_BEQEX,
    S_BNEEX,
    S_JUMP,
    S_ADDIEX,
    S_ADDIWB,
    S_ILLEGAL
  } state_t;

  typedef enum logic [5:0] {
    OP_RTYPE = 6'b000000,
    OP_J     = 6'b000010,
    OP_BEQ   = 6'b000100,
    OP_BNE   = 6'b000101,
    OP_ADDI  = 6'b001000,
    OP_LB    = 6'b100000,
    OP_SB    = 6'b101000
  } opcode_t;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_ONE   = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_SHIMM = 2'b11;

  // irwrite_en is the strobe for the byte selected by byte_idx; the top
  // expands it into the one-hot irwrite bus.
  typedef struct packed {
    logic       mem_req;
    logic       memwrite;
    logic       memtoreg;
    logic       regdst;
    logic       iord;
    logic       pcwrite;
    logic       branch;
    logic       branch_ne;
    logic       alusrc_a;
    logic       regwrite;
    logic [1:0] pcsrc;
    logic [1:0] alusrc_b;
    logic [1:0] aluop;
    logic       irwrite_en;
    logic       illegal_op;
    logic       instr_done;
  } ctrl_t;

  function automatic int byte_idx_width(input int instr_bytes);
    return (instr_bytes > 1) ? $clog2(instr_bytes) : 1;
  endfunction

endpackage

// File: rtl/fetch_counter.sv
// Instruction byte counter: selects which instruction-register byte the
// current fetch loads and flags the final byte of the instruction.
module fetch_counter
  import mc_ctrl_pkg::*;
#(
  parameter int INSTR_BYTES = 4
) (
  input  logic                                      clk,
  input  logic                                      reset_n,
  input  logic                                      inc,
  output logic [byte_idx_width(INSTR_BYTES)-1:0]    byte_idx,
  output logic                                      last
);

  localparam int                IDX_W    = byte_idx_width(INSTR_BYTES);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(INSTR_BYTES - 1);

  logic [IDX_W-1:0] idx_q, idx_d;

  always_comb begin
    idx_d = idx_q;
    if (inc) begin
      idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx_q <= '0;
    end else begin
      idx_q <= idx_d;
    end
  end

  assign byte_idx = idx_q;
  assign last     = (idx_q == LAST_IDX);

endmodule

// File: rtl/mc_control.sv
// Multicycle processor control FSM: multi-byte instruction fetch, decode,
// and per-class execute sequences driving Moore-style datapath controls.
module mc_control
  import mc_ctrl_pkg::*;
#(
  parameter int INSTR_BYTES = 4,
  parameter int WAIT_MEM    = 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [5:0]             op,
  input  logic                   mem_ready,
  output logic                   mem_req,
  output logic                   memwrite,
  output logic                   memtoreg,
  output logic                   regdst,
  output logic                   iord,
  output logic                   pcwrite,
  output logic                   branch,
  output logic                   branch_ne,
  output logic                   alusrcA,
  output logic                   regwrite,
  output logic [1:0]             pcsrc,
  output logic [1:0]             alusrcB,
  output logic [1:0]             aluop,
  output logic [INSTR_BYTES-1:0] irwrite,
  output logic                   illegal_op,
  output logic                   instr_done
);

  localparam int                      IDX_W  = byte_idx_width(INSTR_BYTES);
  localparam logic [INSTR_BYTES-1:0]  IR_ONE = INSTR_BYTES'(1);

  if (INSTR_BYTES != 1 && INSTR_BYTES != 2 && INSTR_BYTES != 4) begin : g_bad_instr_bytes
    $error("mc_control: INSTR_BYTES must be 1, 2 or 4");
  end

  state_t             state_q, state_d;
  ctrl_t              ctrl;
  logic [IDX_W-1:0]   byte_idx;
  logic               last_byte;
  logic               fetch_inc;
  logic               mem_rdy;

  assign mem_rdy = (WAIT_MEM != 0) ? mem_ready : 1'b1;

  fetch_counter #(
    .INSTR_BYTES(INSTR_BYTES)
  ) u_fetch_counter (
    .clk      (clk),
    .reset_n  (reset_n),
    .inc      (fetch_inc),
    .byte_idx (byte_idx),
    .last     (last_byte)
  );

  // NOTE: state flops use non-blocking assignment so every flop samples the
  // pre-edge value of state_d regardless of process evaluation order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    ctrl      = '0;
    fetch_inc = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        ctrl.mem_req  = 1'b1;
        ctrl.alusrc_b = SRCB_ONE;
        if (mem_rdy) begin
          ctrl.pcwrite    = 1'b1;
          ctrl.irwrite_en = 1'b1;
          fetch_inc       = 1'b1;
          if (last_byte) state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        ctrl.alusrc_a = 1'b1;
        ctrl.alusrc_b = SRCB_SHIMM;
        case (op)
          OP_LB, OP_SB: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_RTEXEC;
          OP_BEQ:       state_d = S_BEQEX;
          OP_BNE:       state_d = S_BNEEX;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_ADDIEX;
          default:      state_d = S_ILLEGAL;
        endcase
      end
      S_MEMADR: begin
        ctrl.alusrc_a = 1'b1;
        ctrl.alusrc_b = SRCB_IMM;
        state_d       = (op == OP_SB) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        ctrl.iord    = 1'b1;
        ctrl.mem_req = 1'b1;
        if (mem_rdy) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        ctrl.regwrite   = 1'b1;
        ctrl.memtoreg   = 1'b1;
        ctrl.instr_done = 1'b1;
        state_d         = S_FETCH;
      end
      S_MEMWR: begin
        ctrl.iord     = 1'b1;
        ctrl.mem_req  = 1'b1;
        ctrl.memwrite = 1'b1;
        if (mem_rdy) begin
          ctrl.instr_done = 1'b1;
          state_d         = S_FETCH;
        end
      end
      S_RTEXEC: begin
        ctrl.alusrc_a = 1'b1;
        ctrl.aluop    = ALUOP_FUNCT;
        state_d       = S_RTWB;
      end
      S_RTWB: begin
        ctrl.regdst     = 1'b1;
        ctrl.regwrite   = 1'b1;
        ctrl.instr_done = 1'b1;
        state_d         = S_FETCH;
      end
      S_BEQEX, S_BNEEX: begin
        ctrl.alusrc_a   = 1'b1;
        ctrl.aluop      = ALUOP_SUB;
        ctrl.pcsrc      = PCSRC_ALUOUT;
        ctrl.branch     = (state_q == S_BEQEX);
        ctrl.branch_ne  = (state_q == S_BNEEX);
        ctrl.instr_done = 1'b1;
        state_d         = S_FETCH;
      end
      S_JUMP: begin
        ctrl.pcwrite    = 1'b1;
        ctrl.pcsrc      = PCSRC_JUMP;
        ctrl.instr_done = 1'b1;
        state_d         = S_FETCH;
      end
      S_ADDIEX: begin
        ctrl.alusrc_a = 1'b1;
        ctrl.alusrc_b = SRCB_IMM;
        state_d       = S_ADDIWB;
      end
      S_ADDIWB: begin
        ctrl.regwrite   = 1'b1;
        ctrl.instr_done = 1'b1;
        state_d         = S_FETCH;
      end
      S_ILLEGAL: begin
        ctrl.illegal_op = 1'b1;
        ctrl.instr_done = 1'b1;
        state_d         = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // The state register already sits in FETCH during reset, so only the two
  // fetch-acceptance strobes need masking while reset_n is low.
  assign mem_req    = ctrl.mem_req;
  assign memwrite   = ctrl.memwrite;
  assign memtoreg   = ctrl.memtoreg;
  assign regdst     = ctrl.regdst;
  assign iord       = ctrl.iord;
  assign pcwrite    = ctrl.pcwrite & reset_n;
  assign branch     = ctrl.branch;
  assign branch_ne  = ctrl.branch_ne;
  assign alusrcA    = ctrl.alusrc_a;
  assign regwrite   = ctrl.regwrite;
  assign pcsrc      = ctrl.pcsrc;
  assign alusrcB    = ctrl.alusrc_b;
  assign aluop      = ctrl.aluop;
  assign irwrite    = (ctrl.irwrite_en && reset_n) ? (IR_ONE << byte_idx) : '0;
  assign illegal_op = ctrl.illegal_op;
  assign instr_done = ctrl.instr_done;

endmodule

// File: doc/mc_control.md
MC_CONTROL -- requirements
Module: mc_control

Interface
REQ-001 SHALL have parameter INSTR_BYTES, default 4: memory fetches per instruction; legal values 1, 2, 4; any other value is an elaboration error.
REQ-002 SHALL have parameter WAIT_MEM, default 1: 1 = honour mem_ready; 0 = treat mem_ready as constant 1.
REQ-003 Clocking/reset: one clock; reset is asynchronous and active-low.
REQ-004 Ports, in order:
clk  in  1  clock, rising edge.
reset_n  in  1  asynchronous active-low reset.
op  in  6  opcode field of instruction register.
mem_ready  in  1  memory completes current access this cycle.
mem_req  out  1  memory access request.
memwrite  out  1  memory write enable.
memtoreg  out  1  register write data from memory.
regdst  out  1  destination register is rd.
iord  out  1  memory address from ALU result.
pcwrite  out  1  unconditional PC load.
branch  out  1  PC load if ALU zero.
branch_ne  out  1  PC load if ALU not zero.
alusrcA  out  1  ALU A from register (0 = PC).
regwrite  out  1  register file write.
pcsrc  out  2  00 ALU, 01 ALU register, 10 jump target.
alusrcB  out  2  00 reg, 01 constant 1, 10 immediate, 11 shifted immediate.
aluop  out  2  00 add, 01 subtract, 10 funct-decoded.
irwrite  out  INSTR_BYTES  one-hot instruction byte load enable.
illegal_op  out  1  one-cycle pulse on undefined opcode.
instr_done  out  1  one-cycle pulse in final cycle of every instruction.

Function
REQ-005 All outputs SHALL be combinational from the state, byte_idx and mem_ready; every output not listed for a state is 0.
REQ-006 States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTEXEC, RTWB, BEQEX, BNEEX, JUMP, ADDIEX, ADDIWB, ILLEGAL.
REQ-007 Opcodes: LB 100000, SB 101000, RTYPE 000000, BEQ 000100, BNE 000101, J 000010, ADDI 001000.
REQ-008 FETCH: mem_req=1, alusrcB=01. If mem_ready=1, also pcwrite=1 and irwrite bit byte_idx=1. If mem_ready=0, hold state and byte_idx.
REQ-009 byte_idx: width max(1,clog2(INSTR_BYTES)). On an accepted fetch, byte_idx increments; at INSTR_BYTES-1 it wraps to 0 and the FSM moves to DECODE. With INSTR_BYTES=1, every accepted fetch goes to DECODE.
REQ-010 DECODE: alusrcA=1, alusrcB=11. Next state: LB/SB to MEMADR, RTYPE to RTEXEC, BEQ to BEQEX, BNE to BNEEX, J to JUMP, ADDI to ADDIEX, any other opcode to ILLEGAL.
REQ-011 MEMADR: alusrcA=1, alusrcB=10. LB goes to MEMRD, SB goes to MEMWR.
REQ-012 MEMRD: iord=1, mem_req=1. Hold until mem_ready=1, then go to MEMWB.
REQ-013 MEMWB: regwrite=1, memtoreg=1, instr_done=1. Then go to FETCH.
REQ-014 MEMWR: iord=1, mem_req=1, memwrite=1. Hold until mem_ready=1. On leaving, instr_done=1 and go to FETCH.
REQ-015 RTEXEC: alusrcA=1, aluop=10, then go to RTWB. RTWB: regdst=1, regwrite=1, instr_done=1, then go to FETCH.
REQ-016 BEQEX: alusrcA=1, aluop=01, branch=1, pcsrc=01, instr_done=1. BNEEX is identical except branch_ne=1 in place of branch. Both go to FETCH.
REQ-017 JUMP: pcwrite=1, pcsrc=10, instr_done=1, then go to FETCH.
REQ-018 ADDIEX: alusrcA=1, alusrcB=10, then go to ADDIWB. ADDIWB: regwrite=1, instr_done=1, then go to FETCH.
REQ-019 ILLEGAL: illegal_op=1, instr_done=1, then go to FETCH. No register, memory or PC write is permitted.
REQ-020 An unreachable state encoding SHALL go to FETCH with all outputs 0.
REQ-021 mem_ready is ignored outside FETCH, MEMRD and MEMWR.

Reset
REQ-022 reset_n=0 SHALL immediately force state to FETCH and byte_idx to 0, independent of clk.
REQ-023 During reset: mem_req=1, alusrcB=01, all other outputs 0; pcwrite and irwrite are forced 0 regardless of mem_ready.
REQ-024 Reset asserted mid-instruction or mid-fetch abandons the instruction; the next fetch after release loads byte 0.

Structure
REQ-025 Package mc_ctrl_pkg SHALL hold the state enum, the opcode enum, and named constants for aluop, pcsrc and alusrcB encodings.
REQ-026 Sub-module fetch_counter (parameter INSTR_BYTES; inputs clk, reset_n, inc; outputs byte_idx, last) SHALL implement REQ-009.

Verification
REQ-027 INSTR_BYTES=4, mem_ready=1, op=RTYPE: 4 FETCH cycles with irwrite 0001, 0010, 0100, 1000; DECODE; RTEXEC; RTWB with regwrite=1 and instr_done=1; 7 cycles total.
REQ-028 op=LB, mem_ready low for 3 cycles in MEMRD: FETCH x4, DECODE, MEMADR, MEMRD x4, MEMWB; no pcwrite pulses in MEMRD.
REQ-029 op=BNE and op=BEQ: BNEEX drives branch_ne=1, branch=0, pcsrc=01, aluop=01; BEQEX drives branch=1, branch_ne=0.
REQ-030 op=111111: DECODE goes to ILLEGAL, with illegal_op=1 and regwrite=memwrite=pcwrite=0, then FETCH.
REQ-031 INSTR_BYTES=2, reset_n pulsed low after the first accepted fetch: on release the FSM is in FETCH and the first irwrite is 01.
REQ-032 INSTR_BYTES=1, op=J: FETCH (irwrite=1), DECODE, JUMP (pcwrite=1, pcsrc=10); 3 cycles total.
